shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter with a valid/ready stream interface. It supports logical and arithmetic shifts and rotates in both directions, and uses one registered stage per shift-amount bit. It generalises the fixed 32-bit, single-distance shift/rotate mux stage into a full log-depth shifter that can be back-pressured. It sits between the ALU operand registers and the writeback mux.

---
 rtl/shift_pkg.sv | 35 +++
 rtl/shift_stage.sv | 54 +++++
 rtl/shift_pipe.sv | 99 +++++++++
 tb/tb_shift_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Mode codes, sideband struct and mode helpers shared by the shift_pipe stages.
// The sideband carry field exists only when SHIFT_PIPE_CARRY_EN is defined.
package shift_pkg;

    localparam logic [2:0] MODE_SLL = 3'b000;
    localparam logic [2:0] MODE_SRL = 3'b001;
    localparam logic [2:0] MODE_SRA = 3'b010;
    localparam logic [2:0] MODE_ROR = 3'b011;
    localparam logic [2:0] MODE_ROL = 3'b100;

    // Wide enough for WIDTH up to 256; each stage only looks at its own bit.
    localparam int SB_SHAMT_W = 8;

    typedef struct packed {
        logic [2:0]            mode;
        logic [SB_SHAMT_W-1:0] shamt;
        logic                  sign;
`ifdef SHIFT_PIPE_CARRY_EN
        logic                  carry;
`endif
    } sideband_t;

    function automatic logic is_left(input logic [2:0] mode);
        return (mode == MODE_SLL) || (mode == MODE_ROL);
    endfunction

    function automatic logic is_rot(input logic [2:0] mode);
        return (mode == MODE_ROR) || (mode == MODE_ROL);
    endfunction

    function automatic logic is_pass(input logic [2:0] mode);
        return mode > MODE_ROL;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered conditional right shift/rotate by DIST, one cycle, with its valid bit.
// Loads whenever empty or downstream accepts; holds data and sideband while stalled.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  sideband_t        in_sb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output sideband_t        out_sb
);

    localparam int SEL = $clog2(DIST);

    logic [WIDTH-1:0] shifted;
    logic             fill;

    assign in_ready = !out_valid || out_ready;

    always_comb begin
        fill    = (in_sb.mode == MODE_SRA) && in_sb.sign;
        shifted = in_data;
        if (in_sb.shamt[SEL]) begin
            if (is_rot(in_sb.mode)) begin
                shifted = {in_data[DIST-1:0], in_data[WIDTH-1:DIST]};
            end else begin
                shifted = {{DIST{fill}}, in_data[WIDTH-1:DIST]};
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sb    <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= shifted;
                out_sb   <= in_sb;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR/ROL), SHW register stages, bubble-collapsing
// valid/ready chain so in_ready follows out_ready combinationally. SHIFT_PIPE_CARRY_EN adds out_carry.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef SHIFT_PIPE_CARRY_EN
    ,
    output logic             out_carry
`endif
);

    function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = x[WIDTH-1-i];
        end
        return r;
    endfunction

    // Index 0 is the pipe input, index k+1 is the register of stage k.
    logic [WIDTH-1:0] d   [SHW+1];
    sideband_t        sb  [SHW+1];
    logic             v   [SHW+1];
    logic             rdy [SHW+1];
    sideband_t        sb_entry;

`ifdef SHIFT_PIPE_CARRY_EN
    logic [SHW-1:0] shamt_dec;
    logic [SHW-1:0] shamt_neg;
`endif

    always_comb begin
        sb_entry       = '0;
        sb_entry.mode  = in_mode;
        // Pass-through modes ride the pipe unshifted.
        sb_entry.shamt = is_pass(in_mode) ? '0 : SB_SHAMT_W'(in_shamt);
        sb_entry.sign  = in_data[WIDTH-1];
`ifdef SHIFT_PIPE_CARRY_EN
        shamt_dec = in_shamt - SHW'(1);
        shamt_neg = SHW'(0) - in_shamt;
        if (in_shamt != '0) begin
            case (in_mode)
                MODE_SLL, MODE_ROL:           sb_entry.carry = in_data[shamt_neg];
                MODE_SRL, MODE_SRA, MODE_ROR: sb_entry.carry = in_data[shamt_dec];
                default:                      sb_entry.carry = 1'b0;
            endcase
        end
`endif
    end

    // Left operations reuse the right-shift stages between two bit reversals.
    assign d[0]     = is_left(in_mode) ? bitrev(in_data) : in_data;
    assign sb[0]    = sb_entry;
    assign v[0]     = in_valid;
    assign rdy[SHW] = out_ready;
    assign in_ready = rdy[0];

    for (genvar k = 0; k < SHW; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << k)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (v[k]),
            .in_ready  (rdy[k]),
            .in_data   (d[k]),
            .in_sb     (sb[k]),
            .out_valid (v[k+1]),
            .out_ready (rdy[k+1]),
            .out_data  (d[k+1]),
            .out_sb    (sb[k+1])
        );
    end

    assign out_valid = v[SHW];
    assign out_data  = is_left(sb[SHW].mode) ? bitrev(d[SHW]) : d[SHW];

`ifdef SHIFT_PIPE_CARRY_EN
    assign out_carry = sb[SHW].carry;
`endif

    logic unused_sb;
    assign unused_sb = ^{sb[SHW].shamt, sb[SHW].sign};

endmodule

// File: tb/tb_shift_pipe.sv
// Randomized and directed checks of shift_pipe against a queue-based arithmetic reference.
module tb_shift_pipe;

    localparam int W      = 32;
    localparam int SW     = 5;
    localparam int N_RAND = 10000;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_data   = '0;
    logic [SW-1:0] in_shamt  = '0;
    logic [2:0]    in_mode   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
`ifdef SHIFT_PIPE_CARRY_EN
    logic          out_carry;
`endif

    int         total = 0;
    int         bad   = 0;
    int         rx    = 0;
    logic [W:0] exp_q[$];
    logic       stall_prev = 1'b0;
    logic [W:0] held = '0;
    logic       acc_s = 1'b0;
    logic       ir_s  = 1'b0;

    always #5 clk = ~clk;

    shift_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SHIFT_PIPE_CARRY_EN
        ,
        .out_carry (out_carry)
`endif
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic cur_carry();
`ifdef SHIFT_PIPE_CARRY_EN
        return out_carry;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: {carry, result} from wide shifts of the operand.
    function automatic logic [W:0] ref_op(input logic [W-1:0] d, input int n, input logic [2:0] m);
        logic [63:0]  w;
        logic [W-1:0] r;
        logic         c;
        c = 1'b0;
        r = d;
        case (m)
            3'd0: begin w = {32'b0, d} << n; r = w[31:0];  c = w[32]; end
            3'd1: begin w = {d, 32'b0} >> n; r = w[63:32]; c = w[31]; end
            3'd2: begin w = $signed({d, 32'b0}) >>> n; r = w[63:32]; c = w[31]; end
            3'd3: begin w = {d, d} >> n; r = w[31:0];  c = (n != 0) && r[31]; end
            3'd4: begin w = {d, d} << n; r = w[63:32]; c = (n != 0) && r[0]; end
            default: begin r = d; c = 1'b0; end
        endcase
        return {c, r};
    endfunction

    // One clock: sample at negedge, score transfers due at the next posedge, return at posedge+1.
    task automatic step();
        logic [W:0] e;
        @(negedge clk);
        ir_s  = in_ready;
        acc_s = in_valid && in_ready;
        if (stall_prev) begin
            check_eq("stall_valid", out_valid, 1);
            check_eq("stall_hold", {cur_carry(), out_data}, held);
        end
        stall_prev = out_valid && !out_ready;
        held       = {cur_carry(), out_data};
        if (out_valid && out_ready) begin
            rx++;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_out", out_valid, 0);
            end else begin
                e = exp_q.pop_front();
                check_eq("out_data", out_data, e[W-1:0]);
`ifdef SHIFT_PIPE_CARRY_EN
                check_eq("out_carry", out_carry, e[W]);
`endif
            end
        end
        if (acc_s) exp_q.push_back(ref_op(in_data, int'(in_shamt), in_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic run_one(input string tag, input logic [W-1:0] d, input logic [SW-1:0] n,
                           input logic [2:0] m, input logic [W-1:0] ed, input logic ec);
        int lat;
        in_data   = d;
        in_shamt  = n;
        in_mode   = m;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        check_eq({tag, "_accept"}, acc_s, 1);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        check_eq({tag, "_latency"}, lat, SW - 1);
        check_eq({tag, "_data"}, out_data, ed);
`ifdef SHIFT_PIPE_CARRY_EN
        check_eq({tag, "_carry"}, out_carry, ec);
`else
        if (ec === 1'bx) $display("note: unknown carry expectation for %s", tag);
`endif
        step();
    endtask

    initial begin
        int sent;
        int acc_n;
        int cyc;
        int rx0;

        #12;
        check_eq("reset_out_valid", out_valid, 0);
        check_eq("reset_out_data", out_data, 0);
        check_eq("reset_in_ready", in_ready, 1);
        check_eq("reset_out_carry", cur_carry(), 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_one("sra",      32'h8000_0010, 5'd4,  3'b010, 32'hF800_0001, 1'b0);
        run_one("ror1",     32'h0000_0001, 5'd1,  3'b011, 32'h8000_0000, 1'b1);
        run_one("rol1",     32'h8000_0000, 5'd1,  3'b100, 32'h0000_0001, 1'b1);
        run_one("rol0",     32'hDEAD_BEEF, 5'd0,  3'b100, 32'hDEAD_BEEF, 1'b0);
        run_one("sll31",    32'hFFFF_FFFF, 5'd31, 3'b000, 32'h8000_0000, 1'b1);
        run_one("pass101",  32'h1234_5678, 5'd7,  3'b101, 32'h1234_5678, 1'b0);
        run_one("srl31",    32'h8000_0001, 5'd31, 3'b001, 32'h0000_0001, 1'b0);

        // Back-to-back stream with an 8-cycle consumer stall.
        sent = 0;
        for (int c = 0; c < 60 && !(sent == 8 && exp_q.size() == 0); c++) begin
            out_ready = !(c >= 3 && c < 11);
            in_valid  = (sent < 8);
            in_data   = $urandom;
            in_shamt  = SW'($urandom_range(0, 31));
            in_mode   = 3'($urandom_range(0, 4));
            step();
            if (acc_s) sent++;
            if (c == 10) begin
                check_eq("b2b_full_in_ready", ir_s, 0);
                check_eq("b2b_fill_count", sent, 5);
                check_eq("b2b_stalled_valid", out_valid, 1);
            end
        end
        in_valid = 1'b0;
        check_eq("b2b_sent", sent, 8);
        check_eq("b2b_drained", exp_q.size(), 0);

        // Asynchronous reset with three operations in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            in_shamt = SW'($urandom_range(0, 31));
            in_mode  = 3'b010;
            step();
        end
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", out_valid, 0);
        check_eq("midrst_out_data", out_data, 0);
        check_eq("midrst_in_ready", in_ready, 1);
        check_eq("midrst_out_carry", cur_carry(), 0);
        exp_q.delete();
        stall_prev = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        rx0 = rx;
        repeat (10) step();
        check_eq("midrst_no_stale", rx - rx0, 0);
        run_one("post_rst", 32'h0000_00F0, 5'd4, 3'b001, 32'h0000_000F, 1'b0);

        // Random operands, modes and consumer backpressure.
        acc_n = 0;
        cyc   = 0;
        rx0   = rx;
        in_valid = 1'b0;
        while (acc_n < N_RAND && cyc < 60000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                case ($urandom_range(0, 7))
                    0:       in_data = 32'hFFFF_FFFF;
                    1:       in_data = 32'h8000_0000;
                    2:       in_data = 32'h0000_0001;
                    default: in_data = $urandom;
                endcase
                in_shamt = SW'($urandom_range(0, 31));
                in_mode  = 3'($urandom_range(0, 7));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
            if (acc_s) begin
                acc_n++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) step();
        check_eq("rand_accepted", acc_n, N_RAND);
        check_eq("rand_received", rx - rx0, N_RAND);
        check_eq("rand_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
